spi_master: RTL
===============

// Module: spi_master
// PURPOSE
//  Memory-mapped 8-bit SPI master peripheral on the SoC CPU data bus, alongside GPIO/UART/timer.
//  The top-level address decoder asserts reg_sel for window 0x20030-0x2003F; reads mux reg_do into cpu_data_i.
//  Single-byte, full-duplex transfers. Programmable SCK divider, CPOL/CPHA. Software-driven chip select.
// PARAMETERS
//  DIV_WIDTH   16  width of SCK divider field
//  DIV_RESET   15  CTRL.div value after reset
// PORTS
//  clk       in   1   clock; top instantiates with !clk like other peripherals
//  rstn      in   1   reset, synchronous, active-low
//  reg_sel   in   1   bus address falls in this block's window
//  reg_addr  in   4   byte offset within window (cpu_addr[3:0])
//  reg_we    in   4   byte write enables (cpu_we)
//  reg_di    in   32  write data (cpu_data_o)
//  reg_do    out  32  read data, combinational from reg_addr
//  spi_sck   out  1   serial clock
//  spi_mosi  out  1   serial data out, MSB first
//  spi_miso  in   1   serial data in; no synchroniser in this block
//  spi_cs_n  out  1   chip select, active-low; = ~CTRL.cs
// BEHAVIOUR
//  Registers (a write is any cycle with reg_sel=1, reg_we!=0):
//   0x0 CTRL  [15:0] div, [16] cpol, [17] cpha, [18] cs. Per-byte writes via reg_we. Ignored while busy.
//   0x4 DATA  write: reg_di[7:0] = tx byte, starts transfer. Read: {24'd0, rx_data}.
//   0x8 STAT  [0] busy (RO), [1] done (W1C), [2] ovr (W1C). Write requires reg_we[0]. Other bits read 0.
//   0xC       reads 0; writes ignored.
//  Reset values:
//   div=DIV_RESET, cpol=0, cpha=0, cs=0, rx_data=0, busy=0, done=0, ovr=0.
//   spi_sck=0, spi_mosi=0, spi_cs_n=1.
//  FSM states:
//   IDLE
//    - sck=cpol.
//    - DATA write: load shifter=tx; edge_cnt=0; half_cnt=0; done<=0; -> XFER.
//    - busy=1 from the cycle after the write.
//   XFER
//    - half_cnt counts 0..div; at half_cnt==div, toggle sck, edge_cnt++, half_cnt=0.
//    - Leading edges = odd edge numbers 1,3,..,15; trailing = 2,4,..,16.
//    - CPHA=0: mosi=shifter[7] on entry; sample miso on leading edge; shift on trailing edge.
//    - CPHA=1: shift-out on leading edge; sample on trailing edge.
//    - After edge 16: sck=cpol, rx_data<=shifted byte, done<=1, -> IDLE.
//  Timing:
//   - busy high for exactly 16*(div+1) cycles.
//   - div=0: half period = 1 clk.
//   - div=0xFFFF: half period = 65536 clk, no overflow; half_cnt is DIV_WIDTH bits.
//  Boundaries:
//   - DATA write while busy: ignored; ovr<=1. Transfer in flight is unaffected.
//   - STAT W1C of done on the same cycle that done sets: set wins.
//   - CTRL.cs changes take effect next cycle; writes are ignored while busy, so CS cannot drop mid-byte.
//   - rstn low mid-transfer: next edge returns to IDLE with all reset values; no partial rx_data update.
//   - mosi holds its last bit in IDLE.
// TESTING
//  1. Reset; read CTRL/STAT -> 0x0000000F / 0. spi_cs_n=1, sck=0.
//  2. CTRL=0x00040001 (div=1, mode0, cs=1); DATA=0xA5; loopback miso=mosi:
//     - busy for 32 cycles; mosi sequence 1,0,1,0,0,1,0,1;
//     - then STAT=0x2 and DATA reads 0xA5; spi_cs_n=0 throughout.
//  3. Modes 1/2/3 at div=0, tx 0x3C, slave model returns 0xC3:
//     - rx_data=0xC3; sck idles at cpol; busy exactly 16 cycles.
//  4. DATA=0x11, then DATA=0x22 mid-transfer:
//     - STAT.ovr=1; mosi shifts 0x11 only.
//     - Write STAT=0x6 -> STAT=0.
//  5. Write CTRL=0 while busy -> CTRL unchanged. Assert rstn=0 mid-transfer -> next cycle busy=0, sck=0, rx_data=0.
//  6. div=0xFFFF single transfer: busy exactly 1,048,576 cycles, no early termination.

Source files
------------

// File: rtl/spi_master.sv
// ============================================================================
// Module      : spi_master
// Description : Memory-mapped 8-bit full-duplex SPI master with a
//               programmable SCK divider, CPOL/CPHA and a software chip select.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_master #(
    parameter int DIV_WIDTH = 16,
    parameter int DIV_RESET = 15
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        reg_sel,
    input  logic [3:0]  reg_addr,
    input  logic [3:0]  reg_we,
    input  logic [31:0] reg_di,
    output logic [31:0] reg_do,
    output logic        spi_sck,
    output logic        spi_mosi,
    input  logic        spi_miso,
    output logic        spi_cs_n
);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_XFER   = 1'b1;
    localparam logic [3:0] ADDR_CTRL = 4'h0;
    localparam logic [3:0] ADDR_DATA = 4'h4;
    localparam logic [3:0] ADDR_STAT = 4'h8;

    logic [0:0]           r_state;
    logic [0:0]           w_next_state;
    logic [DIV_WIDTH-1:0] r_div;
    logic                 r_cpol;
    logic                 r_cpha;
    logic                 r_cs;
    logic [DIV_WIDTH-1:0] r_half_cnt;
    logic [3:0]           r_edge_cnt;
    logic [7:0]           r_shift;
    logic                 r_sample;
    logic [7:0]           r_rx;
    logic                 r_done;
    logic                 r_ovr;
    logic                 r_sck;
    logic                 r_mosi;

    logic w_wr;
    logic w_ctrl_wr;
    logic w_data_wr;
    logic w_stat_wr;
    logic w_busy;
    logic w_edge;
    logic w_last;
    logic w_start;
    logic w_lead;
    logic w_trail;
    logic w_ovr_set;
    logic w_ctrl_en;
    logic w_unused;

    assign w_wr      = reg_sel && (reg_we != 4'd0);
    assign w_ctrl_wr = w_wr && (reg_addr == ADDR_CTRL);
    assign w_data_wr = w_wr && (reg_addr == ADDR_DATA);
    assign w_stat_wr = w_wr && (reg_addr == ADDR_STAT) && reg_we[0];
    assign w_busy    = (r_state == ST_XFER);
    assign w_edge    = w_busy && (r_half_cnt == r_div);
    assign w_last    = w_edge && (r_edge_cnt == 4'd15);
    assign w_unused  = ^{reg_di[31:19], reg_we[3]};

    // State register
    always_ff @(posedge clk) begin
        if (!rstn) r_state <= ST_IDLE;
        else       r_state <= w_next_state;
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (w_data_wr) w_next_state = ST_XFER;
            ST_XFER: if (w_last)    w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Edge counter is even before a leading edge, odd before a trailing one
    always_comb begin
        w_start   = (r_state == ST_IDLE) && w_data_wr;
        w_lead    = w_edge && !r_edge_cnt[0];
        w_trail   = w_edge && r_edge_cnt[0];
        w_ovr_set = w_busy && w_data_wr;
        w_ctrl_en = w_ctrl_wr && !w_busy;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_div      <= DIV_WIDTH'(DIV_RESET);
            r_cpol     <= 1'b0;
            r_cpha     <= 1'b0;
            r_cs       <= 1'b0;
            r_half_cnt <= '0;
            r_edge_cnt <= 4'd0;
            r_shift    <= 8'd0;
            r_sample   <= 1'b0;
            r_rx       <= 8'd0;
            r_sck      <= 1'b0;
            r_mosi     <= 1'b0;
        end else begin
            if (w_ctrl_en) begin
                for (int i = 0; i < DIV_WIDTH; i++) begin
                    if (reg_we[i/8]) r_div[i] <= reg_di[i];
                end
                if (reg_we[2]) begin
                    r_cpol <= reg_di[16];
                    r_cpha <= reg_di[17];
                    r_cs   <= reg_di[18];
                end
            end

            if (w_start) begin
                r_shift    <= reg_di[7:0];
                r_half_cnt <= '0;
                r_edge_cnt <= 4'd0;
                r_sck      <= r_cpol;
                if (!r_cpha) r_mosi <= reg_di[7];
            end else if (w_busy) begin
                if (w_edge) begin
                    r_half_cnt <= '0;
                    r_edge_cnt <= r_edge_cnt + 4'd1;
                    r_sck      <= ~r_sck;
                    if (w_lead) begin
                        if (r_cpha) r_mosi   <= r_shift[7];
                        else        r_sample <= spi_miso;
                    end
                    if (w_trail) begin
                        if (r_cpha) begin
                            r_shift <= {r_shift[6:0], spi_miso};
                        end else begin
                            r_shift <= {r_shift[6:0], r_sample};
                            // Keep the final data bit on MOSI once the byte ends
                            if (!w_last) r_mosi <= r_shift[6];
                        end
                    end
                    if (w_last) begin
                        r_rx  <= r_cpha ? {r_shift[6:0], spi_miso} : {r_shift[6:0], r_sample};
                        r_sck <= r_cpol;
                    end
                end else begin
                    r_half_cnt <= r_half_cnt + DIV_WIDTH'(1);
                end
            end else begin
                r_sck <= r_cpol;
            end
        end
    end

    // Status flags: a hardware set beats a same-cycle software clear
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_done <= 1'b0;
            r_ovr  <= 1'b0;
        end else begin
            if (w_last)                      r_done <= 1'b1;
            else if (w_start)                r_done <= 1'b0;
            else if (w_stat_wr && reg_di[1]) r_done <= 1'b0;

            if (w_ovr_set)                   r_ovr <= 1'b1;
            else if (w_stat_wr && reg_di[2]) r_ovr <= 1'b0;
        end
    end

    always_comb begin
        reg_do = 32'd0;
        case (reg_addr)
            ADDR_CTRL: begin
                reg_do[DIV_WIDTH-1:0] = r_div;
                reg_do[18:16]         = {r_cs, r_cpha, r_cpol};
            end
            ADDR_DATA: reg_do[7:0] = r_rx;
            ADDR_STAT: reg_do[2:0] = {r_ovr, r_done, w_busy};
            default:   reg_do = 32'd0;
        endcase
    end

    assign spi_sck  = r_sck;
    assign spi_mosi = r_mosi;
    assign spi_cs_n = ~r_cs;

endmodule

`default_nettype wire
